// File: rtl/logic_gates_checker.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates_checker
// Summary  : On-chip stimulus generator and response checker that sweeps a/b
//            through all four combinations and counts mismatching vectors.
//            Optional first-failure capture: define LOGIC_CHECKER_FIRST_FAIL_EN.
// Revision : 1.0
// ============================================================================
module logic_gates_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] gate_res,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
  ,
  output logic [1:0] first_fail_vec,
  output logic [6:0] first_fail_mask
`endif
);

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_PASS_LAST   = 4'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  npass_q, npass_d;
  logic [3:0]  err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
  logic [1:0]  ff_vec_q, ff_vec_d;
  logic [6:0]  ff_mask_q, ff_mask_d;
`endif

  logic [6:0]  w_expected;
  logic        w_mismatch;

  // Stimulus comes straight from the vector register, so a/b are registered.
  assign a = vec_q[1];
  assign b = vec_q[0];

  assign w_expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign w_mismatch = (gate_res != w_expected);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    npass_d  = npass_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
    ff_vec_d  = ff_vec_q;
    ff_mask_d = ff_mask_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          vec_d    = 2'd0;
          settle_d = 4'd0;
          npass_d  = 4'd0;
          err_d    = 4'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
          ff_vec_d  = 2'd0;
          ff_mask_d = 7'd0;
`endif
        end
      end
      S_DRIVE: begin
        if (settle_q == c_SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = S_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (w_mismatch && (err_q != 4'd15)) begin
          err_d = err_q + 4'd1;
        end
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
        // A zero error count before this vector means it is the first failure.
        if (w_mismatch && (err_q == 4'd0)) begin
          ff_vec_d  = vec_q;
          ff_mask_d = gate_res ^ w_expected;
        end
`endif
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = S_DRIVE;
        end else if (npass_q != c_PASS_LAST) begin
          vec_d   = 2'd0;
          npass_d = npass_q + 4'd1;
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= 2'd0;
      settle_q <= 4'd0;
      npass_q  <= 4'd0;
      err_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
      ff_vec_q  <= 2'd0;
      ff_mask_q <= 7'd0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      npass_q  <= npass_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
      ff_vec_q  <= ff_vec_d;
      ff_mask_q <= ff_mask_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef LOGIC_CHECKER_FIRST_FAIL_EN
  assign first_fail_vec  = ff_vec_q;
  assign first_fail_mask = ff_mask_q;
`endif

endmodule
`default_nettype wire

// File: doc/logic_gates_checker.md
Name: logic_gates_checker

Overview:
- Hardware stimulus generator and response checker for the two-input logic-gate block.
- Drives `a` and `b` through all four input combinations.
- Samples the seven gate outputs returned by the gate block and compares each one with internally computed expected values.
- Counts mismatches and reports pass/fail. This is the on-chip, self-checking counterpart of the simulation-only stimulus/monitor flow.

Parameters:
- SETTLE_CYCLES, default 1: clock cycles each vector is held before sampling; legal range 1..15.
- NUM_PASSES, default 1: number of complete 4-vector sweeps per run; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle run request; honoured only when not busy
- a  output  1  stimulus to the gate block, registered
- b  output  1  stimulus to the gate block, registered
- gate_res  input  7  gate block outputs: [0]=and, [1]=or, [2]=not (of a), [3]=nand, [4]=nor, [5]=xor, [6]=xnor
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next accepted start
- pass  output  1  valid while done=1; 1 when err_count==0
- err_count  output  4  mismatching vectors this run, saturating at 15

Behaviour:
- Reset (async, active-high), takes effect immediately:
  - state=IDLE
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0
  - internal vector, settle and pass counters = 0
- Vector index `vec[1:0]` maps to stimulus as a=vec[1], b=vec[0]. Sequence is 00, 01, 10, 11.
- States:
  - IDLE: start=1 -> DRIVE. On that edge: vec=0, a=0, b=0, err_count=0, done=0, pass=0, busy=1, settle count=0, pass count=0.
  - DRIVE: hold a/b. Increment the settle counter each cycle. After SETTLE_CYCLES cycles in DRIVE -> SAMPLE.
  - SAMPLE (exactly one cycle):
    - expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}, computed from the registered a/b.
    - If gate_res != expected, err_count increments unless already 15. One increment per vector, regardless of how many bits differ.
    - If vec != 3: vec+1, a/b updated on the same edge, -> DRIVE.
    - If vec == 3 and pass count < NUM_PASSES-1: vec wraps to 0, pass count+1, -> DRIVE.
    - Otherwise -> DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). a/b keep the last vector (1,1). start=1 behaves as in IDLE (restart, clearing results).
- start is ignored in DRIVE and SAMPLE. It does not restart, queue or alter the run.
- Latency: done rises on the edge 4*(SETTLE_CYCLES+1)*NUM_PASSES cycles after the start-accept edge. With defaults this is 8 cycles.
- gate_res is treated as combinational from a/b. Sampling occurs only in SAMPLE; gate_res is ignored in all other states.
- Reset asserted mid-run aborts immediately to the reset values. No partial results are retained.
- err_count saturation: 15 + mismatch = 15. No wrap.

Optional Feature:
- Macro: LOGIC_CHECKER_FIRST_FAIL_EN.
- Defined: two extra outputs are added.
  - first_fail_vec (2 bits): vec of the first mismatching vector in the run.
  - first_fail_mask (7 bits): gate_res ^ expected for that vector.
  - Both are captured only on the first mismatch after start, cleared to 0 on reset and on an accepted start, and held thereafter.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Correct gate model, defaults, start pulse -> a/b step 00, 01, 10, 11; done=1 exactly 8 cycles after start; pass=1; err_count=0; busy low in DONE.
- xor output stuck at 0 (gate_res[5]=0) -> mismatches at vectors 01 and 10; err_count=2, pass=0. With the feature enabled: first_fail_vec=01, first_fail_mask=7'b0100000.
- gate_res tied to 7'h00, NUM_PASSES=5 -> 20 mismatches saturate to err_count=15; done after 40 cycles.
- SETTLE_CYCLES=3, correct model -> each vector held 4 cycles; done at cycle 16; pass=1.
- start pulsed at cycle 3 of a run -> ignored; run completes on the original schedule, done at cycle 8.
- rst asserted during vector 10 -> a=b=0, busy=0, err_count=0 immediately. A new start then runs cleanly to pass=1.
